// File: rtl/down_timer_pkg.sv
// Shared definitions for the down_timer block.
//   state_e       : controller states (IDLE, RUN, DONE)
//   DEFAULT_WIDTH : default counter width in bits
package down_timer_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : down_timer_pkg

// File: rtl/down_timer.sv
// Loadable down-counter with terminal-count pulse and optional auto-reload.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   load       in   capture load_value and start a countdown (beats enable)
//   load_value in   [WIDTH] countdown start value
//   enable     in   permit a decrement on this edge (only meaningful in RUN)
//   count      out  [WIDTH] current count, registered
//   tc         out  one-cycle terminal-count pulse, coincident with count == 0
//   busy       out  high in RUN
//   done       out  high in DONE
//   state_dbg  out  current controller state, for observation
//
// Control semantics: load and enable are level qualifiers sampled on each
// rising clk edge; there is no back-pressure, every sampled load is taken.
module down_timer
  import down_timer_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done,
  output state_e           state_dbg
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;

  // Decrement is only legal from RUN with a nonzero count; reaching zero
  // is the terminal-count event.
  logic dec_en;
  logic hit_zero;
  assign dec_en   = (state_q == ST_RUN) && enable && !load;
  assign hit_zero = dec_en && (count_q == WIDTH'(1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = (load_value != '0) ? ST_RUN : ST_DONE;
    end else if (hit_zero && !AUTO_RELOAD) begin
      state_d = ST_DONE;
    end
  end

  // Output logic
  always_comb begin
    busy      = (state_q == ST_RUN);
    done      = (state_q == ST_DONE);
    state_dbg = state_q;
  end

  // Counter datapath
  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (load) begin
      count_d  = load_value;
      reload_d = load_value;
    end else if (dec_en) begin
      if (count_q > WIDTH'(1)) begin
        count_d = count_q - WIDTH'(1);
      end else if (count_q == WIDTH'(1)) begin
        count_d = '0;
        tc_d    = 1'b1;
      end else begin
        // Count sits at 0 in RUN only with auto-reload: the next enabled
        // edge restarts from the stored value, giving a period of
        // reload_val + 1 enabled cycles.
        count_d = reload_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;

endmodule : down_timer

// File: tb/tb_down_timer.sv
// Directed bench for down_timer (WIDTH = 4). Two instances share all
// inputs: u_dut with AUTO_RELOAD = 0, u_dut_ar with AUTO_RELOAD = 1.
module tb_down_timer;
  import down_timer_pkg::*;

  localparam int W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic         load = 1'b0;
  logic [W-1:0] load_value = '0;
  logic         enable = 1'b0;

  logic [W-1:0] count, count_ar;
  logic         tc, tc_ar, busy, busy_ar, done, done_ar;
  state_e       st, st_ar;

  down_timer #(.WIDTH(W), .AUTO_RELOAD(1'b0)) u_dut (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value),
    .enable(enable), .count(count), .tc(tc), .busy(busy), .done(done),
    .state_dbg(st)
  );

  down_timer #(.WIDTH(W), .AUTO_RELOAD(1'b1)) u_dut_ar (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value),
    .enable(enable), .count(count_ar), .tc(tc_ar), .busy(busy_ar),
    .done(done_ar), .state_dbg(st_ar)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load       = 1'b1;
    load_value = v;
    tick();
    load       = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] exp_q[$];
  logic         exp_tc;

  initial begin
    // Reset held low across edges
    enable = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("rst_count", 32'(count), 0);
    check("rst_tc",    32'(tc),    0);
    check("rst_busy",  32'(busy),  0);
    check("rst_done",  32'(done),  0);
    check("rst_state", 32'(st),    32'(ST_IDLE));
    reset = 1'b1;

    // IDLE ignores enable
    repeat (2) tick();
    check("idle_count", 32'(count), 0);
    check("idle_busy",  32'(busy),  0);
    check("idle_state", 32'(st),    32'(ST_IDLE));

    // Basic countdown: 5,4,3,2,1,0 with tc only on 0
    do_load(4'd5);
    check("basic_load_busy", 32'(busy), 1);
    check("basic_load_tc",   32'(tc),   0);
    exp_q = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      exp_tc = (exp_q[i] == 4'd0);
      check("basic_count", 32'(count), 32'(exp_q[i]));
      check("basic_tc",    32'(tc),    32'(exp_tc));
    end
    check("basic_done", 32'(done), 1);
    check("basic_busy", 32'(busy), 0);
    tick();
    check("basic_hold_count", 32'(count), 0);
    check("basic_hold_tc",    32'(tc),    0);
    check("basic_hold_done",  32'(done),  1);

    // Pause at 3 for 3 cycles
    do_load(4'd5);
    tick(); tick();
    check("pause_at3", 32'(count), 3);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("pause_count", 32'(count), 3);
      check("pause_busy",  32'(busy),  1);
      check("pause_tc",    32'(tc),    0);
    end
    enable = 1'b1;
    exp_q = '{4'd2, 4'd1, 4'd0};
    for (int i = 0; i < 3; i++) begin
      tick();
      check("resume_count", 32'(count), 32'(exp_q[i]));
      check("resume_tc",    32'(tc),    32'(i == 2));
    end
    check("resume_done", 32'(done), 1);

    // Auto-reload: 3,2,1,0,3,2,1,0 with tc on each 0
    do_load(4'd3);
    exp_q = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd3, 4'd2, 4'd1, 4'd0};
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      check("ar_count", 32'(count_ar), 32'(exp_q[i]));
      check("ar_tc",    32'(tc_ar),    32'(exp_q[i] == 4'd0));
      check("ar_done",  32'(done_ar),  0);
      check("ar_busy",  32'(busy_ar),  1);
    end

    // Load of zero goes straight to DONE, no tc
    do_load(4'd0);
    for (int i = 0; i < 3; i++) begin
      check("zero_done",  32'(done),  1);
      check("zero_busy",  32'(busy),  0);
      check("zero_tc",    32'(tc),    0);
      check("zero_count", 32'(count), 0);
      tick();
    end

    // Load collides with the 1->0 edge: load wins
    do_load(4'd2);
    tick();
    check("coll_pre", 32'(count), 1);
    do_load(4'd9);
    check("coll_count", 32'(count), 9);
    check("coll_tc",    32'(tc),    0);
    check("coll_state", 32'(st),    32'(ST_RUN));

    // Async reset mid-countdown: 9 -> 6, then reset between edges
    repeat (3) tick();
    check("ar_pre_count", 32'(count), 6);
    #2 reset = 1'b0;
    #1;
    check("arst_count", 32'(count), 0);
    check("arst_tc",    32'(tc),    0);
    check("arst_busy",  32'(busy),  0);
    check("arst_state", 32'(st),    32'(ST_IDLE));
    #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_count", 32'(count), 0);
      check("post_rst_tc",    32'(tc),    0);
      check("post_rst_busy",  32'(busy),  0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #100000;
    n_errors++;
    $display("FAIL timeout: got no finish expected finish by %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_down_timer
